// File: rtl/free_list_pkg.sv
// Shared sizes and circular-pointer helpers for the physical-register free list.
package free_list_pkg;

  localparam int N       = 3;
  localparam int PHYS_SZ = 64;
  localparam int ARCH_SZ = 32;
  localparam int FL_SZ   = PHYS_SZ - ARCH_SZ;
  localparam int PRN_W   = $clog2(PHYS_SZ);
  localparam int IDX_W   = $clog2(FL_SZ);
  localparam int PTR_W   = IDX_W + 1;
  localparam int CNT_W   = $clog2(N + 1);

  typedef logic [PTR_W-1:0] fl_ptr_t;
  typedef logic [PRN_W-1:0] prn_t;

  // Index wraps mod FL_SZ (not necessarily a power of two); the top bit flips on each wrap.
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, logic [CNT_W-1:0] k);
    logic [PTR_W-1:0] sum;
    sum = {1'b0, p[IDX_W-1:0]} + PTR_W'(k);
    if (sum >= PTR_W'(FL_SZ))
      return {~p[IDX_W], IDX_W'(sum - PTR_W'(FL_SZ))};
    return {p[IDX_W], sum[IDX_W-1:0]};
  endfunction

  function automatic fl_ptr_t ptr_diff(fl_ptr_t a, fl_ptr_t b);
    if (a[IDX_W] == b[IDX_W])
      return {1'b0, a[IDX_W-1:0]} - {1'b0, b[IDX_W-1:0]};
    return PTR_W'(FL_SZ) + {1'b0, a[IDX_W-1:0]} - {1'b0, b[IDX_W-1:0]};
  endfunction

endpackage

// File: rtl/free_list_pack.sv
// Compacts a sparse (valid, prn) vector into a dense lowest-index-first list plus its length.
module free_list_pack
  import free_list_pkg::*;
(
  input  logic [N-1:0]       valid,
  input  logic [N*PRN_W-1:0] prn,
  output logic [N*PRN_W-1:0] dense,
  output logic [CNT_W-1:0]   num
);

  // PRN 0 is the hardwired zero register and is never returned to the pool.
  always_comb begin
    dense = '0;
    num   = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (prn[i*PRN_W +: PRN_W] != '0)) begin
        dense[num*PRN_W +: PRN_W] = prn[i*PRN_W +: PRN_W];
        num = num + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/free_list.sv
// R10K free list: circular queue of unmapped PRNs with N-wide alloc, N-wide free and
// checkpoint rollback of the head pointer.
module free_list
  import free_list_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   alloc_num,
  output logic [N*PRN_W-1:0] alloc_prn,
  output logic [CNT_W-1:0]   alloc_avail,
  output logic [N*PRN_W-1:0] prn_invalid,
  input  logic [N-1:0]       free_valid,
  input  logic [N*PRN_W-1:0] free_prn,
  output logic [PTR_W-1:0]   head_out,
  input  logic               rollback,
  input  logic [PTR_W-1:0]   rollback_head,
  output logic [PTR_W-1:0]   count,
  output logic               overflow
);

  prn_t               queue [FL_SZ];
  fl_ptr_t            head;
  fl_ptr_t            tail;
  logic [N*PRN_W-1:0] dense_prn;
  logic [CNT_W-1:0]   free_num;
  fl_ptr_t            count_int;
  fl_ptr_t            space;
  logic [CNT_W-1:0]   avail_int;
  logic [CNT_W-1:0]   granted;
  logic [CNT_W-1:0]   accepted;
  logic               alloc_err;
  logic               free_err;
  logic [IDX_W-1:0]   rd_idx [N];
  logic [IDX_W-1:0]   wr_idx [N];
  logic [N*PRN_W-1:0] alloc_int;
  logic [N*PRN_W-1:0] inval_int;

  free_list_pack u_pack (
    .valid (free_valid),
    .prn   (free_prn),
    .dense (dense_prn),
    .num   (free_num)
  );

  // Free space is judged against the pre-alloc count; anything beyond it is dropped.
  always_comb begin
    fl_ptr_t rp;
    fl_ptr_t wp;
    count_int = ptr_diff(tail, head);
    space     = PTR_W'(FL_SZ) - count_int;
    avail_int = (count_int >= PTR_W'(N)) ? CNT_W'(N) : CNT_W'(count_int);
    alloc_err = !rollback && (alloc_num > avail_int);
    granted   = rollback ? '0 : (alloc_err ? avail_int : alloc_num);
    free_err  = PTR_W'(free_num) > space;
    accepted  = free_err ? CNT_W'(space) : free_num;
    alloc_int = '0;
    inval_int = '0;
    for (int i = 0; i < N; i++) begin
      rp        = ptr_add(head, CNT_W'(i));
      wp        = ptr_add(tail, CNT_W'(i));
      rd_idx[i] = rp[IDX_W-1:0];
      wr_idx[i] = wp[IDX_W-1:0];
      if (CNT_W'(i) < avail_int)
        alloc_int[i*PRN_W +: PRN_W] = queue[rd_idx[i]];
      if (CNT_W'(i) < granted)
        inval_int[i*PRN_W +: PRN_W] = queue[rd_idx[i]];
    end
  end

  assign alloc_prn   = reset ? alloc_int : '0;
  assign alloc_avail = reset ? avail_int : '0;
  assign prn_invalid = reset ? inval_int : '0;
  assign head_out    = head;
  assign count       = count_int;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < FL_SZ; k++)
        queue[k] <= PRN_W'(ARCH_SZ + k);
      head     <= '0;
      tail     <= {1'b1, IDX_W'(0)};
      overflow <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (CNT_W'(j) < accepted)
          queue[wr_idx[j]] <= dense_prn[j*PRN_W +: PRN_W];
      end
      head     <= rollback ? rollback_head : ptr_add(head, granted);
      tail     <= ptr_add(tail, accepted);
      overflow <= overflow | alloc_err | free_err;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a driver pushes expected outputs from an unbounded-index
// queue model, a monitor pops and compares them each cycle.
module tb_free_list;
  import free_list_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [CNT_W-1:0]   alloc_num = '0;
  logic [N*PRN_W-1:0] alloc_prn;
  logic [CNT_W-1:0]   alloc_avail;
  logic [N*PRN_W-1:0] prn_invalid;
  logic [N-1:0]       free_valid = '0;
  logic [N*PRN_W-1:0] free_prn = '0;
  logic [PTR_W-1:0]   head_out;
  logic               rollback = 1'b0;
  logic [PTR_W-1:0]   rollback_head = '0;
  logic [PTR_W-1:0]   count;
  logic               overflow;

  free_list dut (
    .clock(clock), .reset(reset), .alloc_num(alloc_num), .alloc_prn(alloc_prn),
    .alloc_avail(alloc_avail), .prn_invalid(prn_invalid), .free_valid(free_valid),
    .free_prn(free_prn), .head_out(head_out), .rollback(rollback),
    .rollback_head(rollback_head), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit chk_state;
    int avail;
    int aprn [N];
    int inval [N];
    int cnt;
    int hd;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: absolute (never-wrapping) head/tail indices over a circular store.
  int mem [FL_SZ];
  int m_head = 0;
  int m_tail = 0;
  bit m_ovf  = 1'b0;

  function automatic void check(string name, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [N*PRN_W-1:0] pk(int a, int b, int c);
    logic [N*PRN_W-1:0] r;
    r = '0;
    r[0*PRN_W +: PRN_W] = PRN_W'(a);
    r[1*PRN_W +: PRN_W] = PRN_W'(b);
    r[2*PRN_W +: PRN_W] = PRN_W'(c);
    return r;
  endfunction

  function automatic int n_frees(logic [N-1:0] fv, logic [N*PRN_W-1:0] fp);
    int k = 0;
    for (int i = 0; i < N; i++)
      if (fv[i] && fp[i*PRN_W +: PRN_W] != '0) k++;
    return k;
  endfunction

  function automatic int slot(logic [N*PRN_W-1:0] v, int i);
    return int'(v[i*PRN_W +: PRN_W]);
  endfunction

  task automatic step(input bit rst, input int an, input logic [N-1:0] fv,
                      input logic [N*PRN_W-1:0] fp, input bit rb, input int rh_abs);
    exp_t e;
    int   cnt, av, gr, acc;
    int   fl[$];
    @(negedge clock);
    reset         = rst ? 1'b0 : 1'b1;
    alloc_num     = CNT_W'(an);
    free_valid    = fv;
    free_prn      = fp;
    rollback      = rb;
    rollback_head = PTR_W'(rh_abs % 64);
    cnt = m_tail - m_head;
    av  = (cnt < N) ? cnt : N;
    gr  = rb ? 0 : ((an < av) ? an : av);
    e.chk_state = !rst;
    e.avail     = rst ? 0 : av;
    for (int i = 0; i < N; i++) begin
      e.aprn[i]  = mem[(m_head + i) % FL_SZ];
      e.inval[i] = (!rst && i < gr) ? mem[(m_head + i) % FL_SZ] : 0;
    end
    e.cnt = cnt;
    e.hd  = m_head % 64;
    e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge clock);
    if (rst) begin
      for (int k = 0; k < FL_SZ; k++) mem[k] = ARCH_SZ + k;
      m_head = 0;
      m_tail = FL_SZ;
      m_ovf  = 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (fv[i] && fp[i*PRN_W +: PRN_W] != '0) fl.push_back(int'(fp[i*PRN_W +: PRN_W]));
      if (!rb && an > av) m_ovf = 1'b1;
      acc = fl.size();
      if (acc > FL_SZ - cnt) begin
        m_ovf = 1'b1;
        acc   = FL_SZ - cnt;
      end
      for (int j = 0; j < acc; j++) mem[(m_tail + j) % FL_SZ] = fl[j];
      m_tail = m_tail + acc;
      m_head = rb ? rh_abs : m_head + gr;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  // Monitor: outputs are valid every cycle, so each driven cycle yields one entry to compare.
  exp_t mon_e;
  always @(negedge clock) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("alloc_avail", 32'(alloc_avail), mon_e.avail);
      for (int i = 0; i < N; i++) begin
        if (i < mon_e.avail)
          check($sformatf("alloc_prn[%0d]", i), 32'(alloc_prn[i*PRN_W +: PRN_W]), mon_e.aprn[i]);
        check($sformatf("prn_invalid[%0d]", i), 32'(prn_invalid[i*PRN_W +: PRN_W]), mon_e.inval[i]);
      end
      if (mon_e.chk_state) begin
        check("count", 32'(count), mon_e.cnt);
        check("head_out", 32'(head_out), mon_e.hd);
        check("overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int an, snap, tn, h;
    logic [N-1:0]       fv;
    logic [N*PRN_W-1:0] fp;
    bit rb;

    // Reset and initial contents
    step(1'b1, 0, '0, '0, 1'b0, 0);
    step(1'b1, 0, '0, '0, 1'b0, 0);
    idle();
    #1;
    check("rst_count", 32'(count), 32);
    check("rst_avail", 32'(alloc_avail), 3);
    check("rst_slot0", slot(alloc_prn, 0), 32);
    check("rst_slot1", slot(alloc_prn, 1), 33);
    check("rst_slot2", slot(alloc_prn, 2), 34);
    check("rst_ovf", 32'(overflow), 0);

    // Drain all 32 in order
    repeat (10) step(1'b0, 3, '0, '0, 1'b0, 0);
    step(1'b0, 2, '0, '0, 1'b0, 0);
    #1;
    check("drain_count", 32'(count), 0);
    check("drain_avail", 32'(alloc_avail), 0);
    check("drain_inval", 32'(prn_invalid), 0);
    check("drain_ovf", 32'(overflow), 0);

    // Sparse free of 7 and 40; no bypass to alloc in the same cycle
    step(1'b0, 0, 3'b101, pk(7, 55, 40), 1'b0, 0);
    idle();
    #1;
    check("free_count", 32'(count), 2);
    check("free_slot0", slot(alloc_prn, 0), 7);
    check("free_slot1", slot(alloc_prn, 1), 40);

    // Simultaneous alloc and free
    step(1'b0, 0, 3'b111, pk(10, 11, 12), 1'b0, 0);
    step(1'b0, 2, 3'b111, pk(13, 14, 15), 1'b0, 0);
    #1;
    check("sim_count", 32'(count), 6);
    check("sim_head", 32'(head_out), 34);

    // Rollback to a checkpoint with a same-cycle alloc that must be ignored
    h = m_head;
    step(1'b0, 3, '0, '0, 1'b0, 0);
    step(1'b0, 3, '0, '0, 1'b0, 0);
    step(1'b0, 3, '0, '0, 1'b1, h);
    #1;
    check("rb_head", 32'(head_out), 34);
    check("rb_count", 32'(count), 6);
    check("rb_slot0", slot(alloc_prn, 0), 10);
    check("rb_slot1", slot(alloc_prn, 1), 11);
    check("rb_slot2", slot(alloc_prn, 2), 12);

    // Free while full is dropped and flags overflow
    step(1'b1, 0, '0, '0, 1'b0, 0);
    idle();
    step(1'b0, 0, 3'b111, pk(5, 6, 9), 1'b0, 0);
    #1;
    check("full_count", 32'(count), 32);
    check("full_ovf", 32'(overflow), 1);

    // Over-alloc with one PRN left, sticky overflow, zero-PRN free
    step(1'b1, 0, '0, '0, 1'b0, 0);
    idle();
    repeat (10) step(1'b0, 3, '0, '0, 1'b0, 0);
    step(1'b0, 1, '0, '0, 1'b0, 0);
    step(1'b0, 3, '0, '0, 1'b0, 0);
    #1;
    check("over_count", 32'(count), 0);
    check("over_ovf", 32'(overflow), 1);
    idle();
    #1;
    check("over_sticky", 32'(overflow), 1);
    step(1'b0, 0, 3'b111, pk(0, 0, 0), 1'b0, 0);
    #1;
    check("zero_free_count", 32'(count), 0);

    // Randomised traffic with occasional checkpoint rollbacks
    step(1'b1, 0, '0, '0, 1'b0, 0);
    step(1'b1, 0, '0, '0, 1'b0, 0);
    snap = -1;
    for (int c = 0; c < 400; c++) begin
      an = $urandom_range(0, 3);
      fv = N'($urandom);
      fp = '0;
      for (int i = 0; i < N; i++)
        fp[i*PRN_W +: PRN_W] = ($urandom_range(0, 7) == 0) ? '0 : PRN_W'($urandom_range(1, 63));
      rb = 1'b0;
      if (snap >= 0 && $urandom_range(0, 9) == 0) begin
        tn = m_tail + ((n_frees(fv, fp) < FL_SZ - (m_tail - m_head)) ?
                       n_frees(fv, fp) : FL_SZ - (m_tail - m_head));
        if (snap <= m_head && tn - snap <= FL_SZ) rb = 1'b1;
      end
      step(1'b0, an, fv, fp, rb, snap);
      if (!rb && $urandom_range(0, 7) == 0) snap = m_head;
    end

    for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clock);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
